// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline MEM stage.
// Takes the EX-stage ALU result as an effective address or as a pass-through
// result. Runs loads and stores over a single-outstanding req/ack bus and
// registers the MEM/WB fields. Stall_MEM holds EX and the upstream stages
// while an access is pending.
// Optional feature: define MEM_TIMEOUT_EN to abandon an access that has
// waited TIMEOUT_CYCLES cycles without an ack. The access then retires with a
// fault.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Valid_EX,
  input  logic [31:0] ALU_Result_EX,
  input  logic [31:0] Write_Data_EX,
  input  logic [4:0]  Write_Register_EX,
  input  logic        MemRead_EX,
  input  logic        MemWrite_EX,
  input  logic        RegWrite_EX,
  input  logic        MemtoReg_EX,
  output logic        Stall_MEM,
  output logic        Bus_Req,
  output logic        Bus_We,
  output logic [31:0] Bus_Addr,
  output logic [31:0] Bus_WData,
  input  logic        Bus_Ack,
  input  logic [31:0] Bus_RData,
  output logic        Valid_MEM,
  output logic        RegWrite_MEM,
  output logic        MemtoReg_MEM,
  output logic        Mem_Fault_MEM,
  output logic [31:0] ALU_Result_MEM,
  output logic [31:0] Read_Data_MEM,
  output logic [4:0]  Write_Register_MEM
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t      state;
  logic        memop;
  logic        bad;
  logic        accept;
  logic        timeout_hit;

  // Copy of the EX fields taken when an access starts. These fields are
  // replayed into the MEM register when the access retires.
  logic        hold_valid;
  logic        hold_regwrite;
  logic        hold_memtoreg;
  logic        hold_read;
  logic [4:0]  hold_wreg;
  logic [31:0] hold_alu;

  // Decode of the instruction in EX: a memory op, and whether it is illegal.
  assign memop  = Valid_EX & (MemRead_EX | MemWrite_EX);
  assign bad    = memop & ((ALU_Result_EX[1:0] != 2'b00) | (MemRead_EX & MemWrite_EX));
  assign accept = (state == ST_IDLE) & memop & ~bad;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_VAL = 8'(TIMEOUT_CYCLES);
  logic [7:0] wait_cnt;

  assign timeout_hit = (state == ST_WAIT) & ~Bus_Ack & (wait_cnt == TIMEOUT_VAL);

  // Count WAIT cycles without an ack; cleared whenever a new access starts.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wait_cnt <= 8'd0;
    end else if (accept) begin
      wait_cnt <= 8'd0;
    end else if ((state == ST_WAIT) && !Bus_Ack && !timeout_hit) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // The stall is combinational on Bus_Ack, so EX advances on the same edge
  // that retires the access. It is also released on the edge that abandons
  // a timed-out access. Reset forces it low so that nothing upstream stays
  // frozen.
  assign Stall_MEM = Reset_n &
                     (accept | ((state == ST_WAIT) & ~Bus_Ack & ~timeout_hit));

  // FSM, bus request registers and the MEM/WB pipeline register.
  // NOTE: this is sequential state, so every assignment is non-blocking. All
  // registers then update together from the values seen before the edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state              <= ST_IDLE;
      Bus_Req            <= 1'b0;
      Bus_We             <= 1'b0;
      Bus_Addr           <= 32'd0;
      Bus_WData          <= 32'd0;
      hold_valid         <= 1'b0;
      hold_regwrite      <= 1'b0;
      hold_memtoreg      <= 1'b0;
      hold_read          <= 1'b0;
      hold_wreg          <= 5'd0;
      hold_alu           <= 32'd0;
      Valid_MEM          <= 1'b0;
      RegWrite_MEM       <= 1'b0;
      MemtoReg_MEM       <= 1'b0;
      Mem_Fault_MEM      <= 1'b0;
      ALU_Result_MEM     <= 32'd0;
      Read_Data_MEM      <= 32'd0;
      Write_Register_MEM <= 5'd0;
    end else begin
      // Default: the MEM register takes a bubble. The branches below override it.
      Valid_MEM     <= 1'b0;
      RegWrite_MEM  <= 1'b0;
      MemtoReg_MEM  <= 1'b0;
      Mem_Fault_MEM <= 1'b0;
      Read_Data_MEM <= 32'd0;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            state         <= ST_WAIT;
            Bus_Req       <= 1'b1;
            Bus_We        <= MemWrite_EX;
            Bus_Addr      <= ALU_Result_EX;
            Bus_WData     <= Write_Data_EX;
            hold_valid    <= Valid_EX;
            hold_regwrite <= RegWrite_EX;
            hold_memtoreg <= MemtoReg_EX;
            hold_read     <= MemRead_EX;
            hold_wreg     <= Write_Register_EX;
            hold_alu      <= ALU_Result_EX;
          end else begin
            // Pass-through. A bad access retires at once, flagged and without
            // writing back.
            Valid_MEM          <= Valid_EX;
            RegWrite_MEM       <= Valid_EX & RegWrite_EX & ~bad;
            MemtoReg_MEM       <= Valid_EX & MemtoReg_EX;
            Mem_Fault_MEM      <= bad;
            ALU_Result_MEM     <= ALU_Result_EX;
            Write_Register_MEM <= Write_Register_EX;
          end
        end

        ST_WAIT: begin
          if (Bus_Ack) begin
            state              <= ST_IDLE;
            Bus_Req            <= 1'b0;
            Valid_MEM          <= hold_valid;
            RegWrite_MEM       <= hold_regwrite;
            MemtoReg_MEM       <= hold_memtoreg;
            ALU_Result_MEM     <= hold_alu;
            Write_Register_MEM <= hold_wreg;
            Read_Data_MEM      <= hold_read ? Bus_RData : 32'd0;
          end else if (timeout_hit) begin
            state              <= ST_IDLE;
            Bus_Req            <= 1'b0;
            Valid_MEM          <= hold_valid;
            MemtoReg_MEM       <= hold_memtoreg;
            Mem_Fault_MEM      <= 1'b1;
            ALU_Result_MEM     <= hold_alu;
            Write_Register_MEM <= hold_wreg;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage sitting directly downstream of the EX-stage ALU. Takes the ALU result as an effective address (or as a pass-through result), runs loads and stores over a single-outstanding req/ack data bus, and registers the MEM/WB fields for write-back. It asserts a stall back to EX and earlier stages while an access is pending, and reports misaligned or timed-out accesses as a fault.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: maximum WAIT cycles before an access is abandoned (range 1..255; 8-bit counter).

Ports:
- Clk  in  1  pipeline clock; all state updates on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Valid_EX  in  1  instruction in EX is valid
- ALU_Result_EX  in  32  address for loads/stores; result for other instructions
- Write_Data_EX  in  32  store data (rt value)
- Write_Register_EX  in  5  destination register
- MemRead_EX, MemWrite_EX, RegWrite_EX, MemtoReg_EX  in  1 each  control bits from EX
- Stall_MEM  out  1  combinational; holds EX and all upstream stages
- Bus_Req  out  1  registered access request
- Bus_We  out  1  1 = write, 0 = read
- Bus_Addr  out  32  word address (low 2 bits always 00)
- Bus_WData  out  32  write data
- Bus_Ack  in  1  one-cycle completion strobe
- Bus_RData  in  32  read data; valid when Bus_Ack=1
- Valid_MEM, RegWrite_MEM, MemtoReg_MEM, Mem_Fault_MEM  out  1 each  registered MEM/WB control
- ALU_Result_MEM, Read_Data_MEM  out  32 each  registered MEM/WB data
- Write_Register_MEM  out  5  registered destination register

## Operation
- Definitions:
  - memop = Valid_EX & (MemRead_EX | MemWrite_EX).
  - bad = memop & (ALU_Result_EX[1:0] != 0 | (MemRead_EX & MemWrite_EX)).
- FSM states: IDLE, WAIT.
- IDLE, no memop:
  - MEM register loads the EX fields next edge.
  - Read_Data_MEM = 0, Mem_Fault_MEM = 0, Stall_MEM = 0.
  - Valid_EX = 0 loads Valid_MEM = 0 and RegWrite_MEM = 0.
- IDLE, bad:
  - No bus request and no stall.
  - MEM register loads with Mem_Fault_MEM = 1, RegWrite_MEM = 0.
- IDLE, legal memop:
  - Stall_MEM = 1.
  - Next edge: Bus_Req = 1, Bus_We = MemWrite_EX, Bus_Addr = ALU_Result_EX, Bus_WData = Write_Data_EX; counter cleared; go to WAIT.
  - MEM register loads a bubble (Valid_MEM = 0, RegWrite_MEM = 0).
- WAIT:
  - Stall_MEM = ~Bus_Ack.
  - Bus_Req, Bus_We, Bus_Addr and Bus_WData stay stable until the ack edge.
  - On Bus_Ack:
    - Bus_Req drops next edge.
    - MEM register loads the held EX fields.
    - Read_Data_MEM = Bus_RData for reads, 0 for writes.
    - Return to IDLE; EX advances on the same edge.
  - Without Bus_Ack: MEM register loads a bubble each cycle.
- Bus_Ack while in IDLE is ignored.
- Reset: all outputs and state clear immediately (asynchronous).
  - Bus_Req drops even mid-access; FSM to IDLE, counter 0.
  - All MEM outputs 0, Stall_MEM 0 once reset is released.

## Timing
- Non-memory instruction: 1-cycle latency EX→MEM, no stall.
- Load/store: memop presented in cycle 0 (stall), Bus_Req rises in cycle 1; ack in cycle k≥1 gives MEM outputs valid in cycle k+1.
  - Minimum total: 2 cycles; 1 stall cycle when ack arrives in cycle 1.
- Back-to-back memops: the second sees IDLE on the cycle after the ack edge. Bus_Req is low for exactly one cycle between accesses.
- Stall_MEM depends combinationally on Bus_Ack. There is no registered path in the stall loop.

## Configuration
- MEM_TIMEOUT_EN defined:
  - In WAIT, the counter increments each cycle without ack.
  - When the counter equals TIMEOUT_CYCLES, the next edge does the following:
    - drops Bus_Req
    - loads the MEM register with Mem_Fault_MEM = 1, RegWrite_MEM = 0
    - returns to IDLE with Stall_MEM = 0
  - An ack coinciding with the timeout cycle wins and completes normally.
- MEM_TIMEOUT_EN undefined:
  - No counter; WAIT persists until Bus_Ack.
  - Mem_Fault_MEM comes only from bad accesses; TIMEOUT_CYCLES is unused.

## Test plan
- Add result 0x0000_0010, RegWrite_EX = 1, no memop: next cycle ALU_Result_MEM = 0x10, RegWrite_MEM = 1, Stall_MEM never high.
- Load at 0x100, Bus_Ack in the first Req cycle with RData 0xDEAD_BEEF: Stall_MEM high 1 cycle, Bus_Addr = 0x100, Read_Data_MEM = 0xDEAD_BEEF, MemtoReg_MEM = 1.
- Store at 0x204 with data 0x1234_5678, ack after 5 cycles: Bus_We = 1 and Bus_WData stable for 5 cycles, Stall_MEM high 5 cycles, then Valid_MEM = 1, Read_Data_MEM = 0.
- Load at 0x102: no Bus_Req, no stall, Mem_Fault_MEM = 1, RegWrite_MEM = 0 next cycle.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES = 4, no ack: Bus_Req drops after the timeout, Mem_Fault_MEM = 1. A late Bus_Ack is ignored.
- Reset_n pulled low in WAIT: Bus_Req, Stall_MEM and all MEM outputs 0 without waiting for a clock edge; after release, a new load completes normally.
